// File: rtl/sp_ram_arb_pkg.sv
// sp_ram_arb_pkg: shared constants for the two-port single-port-RAM arbiter.
//   NUM_PORTS            number of requesters (fixed at 2)
//   PORT_LOOKUP/REFILL   port index names used by integrators
//   RAM_WR/RAM_RD        RAM rdw_en encoding
package sp_ram_arb_pkg;
    localparam int NUM_PORTS   = 2;
    localparam int PORT_LOOKUP = 0;
    localparam int PORT_REFILL = 1;

    localparam logic RAM_WR = 1'b1;
    localparam logic RAM_RD = 1'b0;
endpackage

// File: rtl/sp_ram_arb_rsp_slot.sv
// sp_ram_arb_rsp_slot: per-port read response path.
// Tracks a read that was granted last cycle (inflight), bypasses the RAM
// output straight to the port, and parks the data in a hold register when
// the consumer is not ready.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rd_grant_i      a read for this port is granted this cycle
//   rsp_ready_i     consumer accepts rsp_rdata_o this cycle
//   ram_data_i      RAM data_out (valid the cycle after a read)
//   busy_o          slot will still hold data at the end of this cycle
//   rsp_valid_o     response valid
//   rsp_rdata_o     response data (last value kept while not valid)
module sp_ram_arb_rsp_slot #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_grant_i,
    input  logic                  rsp_ready_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  busy_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o
);
    logic                  inflight_q, inflight_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // data_q doubles as the hold register and the "last value" shown while
    // idle: it captures the RAM output on every inflight cycle.
    always_comb begin
        inflight_d   = rd_grant_i;
        hold_valid_d = hold_valid_q;
        data_d       = data_q;
        if (inflight_q) begin
            data_d       = ram_data_i;
            hold_valid_d = !rsp_ready_i;
        end else if (hold_valid_q && rsp_ready_i) begin
            hold_valid_d = 1'b0;
        end
        rsp_valid_o = !rst && (inflight_q || hold_valid_q);
        rsp_rdata_o = inflight_q ? ram_data_i : data_q;
        busy_o      = (inflight_q || hold_valid_q) && !rsp_ready_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            data_q       <= '0;
        end else begin
            inflight_q   <= inflight_d;
            hold_valid_q <= hold_valid_d;
            data_q       <= data_d;
        end
    end
endmodule

// File: rtl/sp_ram_arb.sv
// sp_ram_arb: grants one of two requesters per cycle onto a single-port RAM
// and returns read data through a per-port response slot.
// Optional feature macro: SP_RAM_ARB_RR_EN (round-robin instead of fixed
// priority with port 0 winning).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o       per-port request handshake
//   req_we_i                      1=write, 0=read
//   req_addr_i/wdata_i/wmask_i    per-port packed request fields
//   rsp_valid_o/rsp_ready_i       per-port read response handshake
//   rsp_rdata_o                   per-port packed read data
//   ram_*                         RAM wrapper functional port
//
// Handshakes: a request transfers on a cycle where req_valid_i[i] and
// req_ready_o[i] are both 1; a response transfers where rsp_valid_o[i] and
// rsp_ready_i[i] are both 1. Valid never depends on ready of the same
// channel; req_ready_o may depend on rsp_ready_i.
module sp_ram_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid_i,
    output logic [NUM_PORTS-1:0]            req_ready_o,
    input  logic [NUM_PORTS-1:0]            req_we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wmask_i,
    output logic [NUM_PORTS-1:0]            rsp_valid_o,
    input  logic [NUM_PORTS-1:0]            rsp_ready_i,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                            ram_clk_en_o,
    output logic                            ram_rdw_en_o,
    output logic [ADDR_WIDTH-1:0]           ram_addr_o,
    output logic [DATA_WIDTH-1:0]           ram_data_o,
    output logic [DATA_WIDTH-1:0]           ram_mask_o,
    input  logic [DATA_WIDTH-1:0]           ram_data_i
);
    logic [NUM_PORTS-1:0] busy;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] gnt;
    logic [NUM_PORTS-1:0] rd_grant;
    logic                 gnt_any;
    logic                 gnt_idx;

    // A read may only go when its slot is guaranteed empty next cycle,
    // which keeps inflight and hold mutually exclusive.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = !rst && req_valid_i[i] && (req_we_i[i] || !busy[i]);
        end
    end

`ifdef SP_RAM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        if (elig[PORT_LOOKUP] && elig[PORT_REFILL]) begin
            gnt_idx = !last_grant_q;
        end else begin
            gnt_idx = elig[PORT_REFILL];
        end
        last_grant_d = gnt_any ? gnt_idx : last_grant_q;
    end

    // Reset to port 1 so that port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        gnt_idx = !elig[PORT_LOOKUP];
    end
`endif

    always_comb begin
        gnt_any               = |elig;
        gnt[PORT_LOOKUP]      = gnt_any && !gnt_idx;
        gnt[PORT_REFILL]      = gnt_any && gnt_idx;
        req_ready_o           = gnt;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_grant[i] = gnt[i] && (req_we_i[i] == RAM_RD);
        end

        ram_clk_en_o = gnt_any;
        ram_rdw_en_o = RAM_RD;
        ram_addr_o   = '0;
        ram_data_o   = '0;
        ram_mask_o   = '0;
        if (gnt_any) begin
            if (gnt_idx) begin
                ram_rdw_en_o = req_we_i[PORT_REFILL];
                ram_addr_o   = req_addr_i[PORT_REFILL*ADDR_WIDTH +: ADDR_WIDTH];
                ram_data_o   = req_wdata_i[PORT_REFILL*DATA_WIDTH +: DATA_WIDTH];
                ram_mask_o   = req_wmask_i[PORT_REFILL*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                ram_rdw_en_o = req_we_i[PORT_LOOKUP];
                ram_addr_o   = req_addr_i[PORT_LOOKUP*ADDR_WIDTH +: ADDR_WIDTH];
                ram_data_o   = req_wdata_i[PORT_LOOKUP*DATA_WIDTH +: DATA_WIDTH];
                ram_mask_o   = req_wmask_i[PORT_LOOKUP*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
        sp_ram_arb_rsp_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .rd_grant_i (rd_grant[g]),
            .rsp_ready_i(rsp_ready_i[g]),
            .ram_data_i (ram_data_i),
            .busy_o     (busy[g]),
            .rsp_valid_o(rsp_valid_o[g]),
            .rsp_rdata_o(rsp_rdata_o[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_sp_ram_arb.sv
// tb_sp_ram_arb: directed bench for sp_ram_arb with a behavioural RAM model.
module tb_sp_ram_arb;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata, req_wmask;
    logic [1:0]      rsp_valid, rsp_ready;
    logic [2*DW-1:0] rsp_rdata;
    logic            ram_clk_en, ram_rdw_en;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata, ram_mask, ram_dout;
    logic            mem_clear;
    logic [DW-1:0]   mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    sp_ram_arb dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wmask_i (req_wmask),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .ram_clk_en_o(ram_clk_en),
        .ram_rdw_en_o(ram_rdw_en),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_wdata),
        .ram_mask_o  (ram_mask),
        .ram_data_i  (ram_dout)
    );

    // Single-port RAM: masked write, registered read output.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            ram_dout <= '0;
        end else if (ram_clk_en) begin
            if (ram_rdw_en) mem[ram_addr] <= (mem[ram_addr] & ~ram_mask) | (ram_wdata & ram_mask);
            else            ram_dout <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_valid[p]           = 1'b1;
        req_we[p]              = we;
        req_addr[p*AW +: AW]   = a;
        req_wdata[p*DW +: DW]  = d;
        req_wmask[p*DW +: DW]  = m;
    endtask

    task automatic drop(input int p);
        req_valid[p] = 1'b0;
    endtask

    // Single-cycle write by one port with no contention.
    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        drive(p, 1'b1, a, d, m);
        sample();
        check_eq("wr_ready", DW'(req_ready), DW'(2'b01 << p));
        check_eq("wr_rdw_en", DW'(ram_rdw_en), 1);
        tick();
        drop(p);
    endtask

    initial begin
        rst = 1'b1; mem_clear = 1'b1;
        req_valid = 2'b11; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        rsp_ready = 2'b00;

        // Reset state: requests present but nothing granted or driven.
        tick();
        mem_clear = 1'b0;
        sample();
        check_eq("rst_req_ready", DW'(req_ready), 0);
        check_eq("rst_rsp_valid", DW'(rsp_valid), 0);
        check_eq("rst_clk_en", DW'(ram_clk_en), 0);
        check_eq("rst_addr", DW'(ram_addr), 0);
        check_eq("rst_mask", ram_mask, 0);
        tick();
        req_valid = 2'b00; rst = 1'b0; rsp_ready = 2'b11;

        // Single read after a port-1 write.
        wr(1, 10'h005, 64'hDEAD_BEEF, ONES);
        drive(0, 1'b0, 10'h005, '0, '0);
        sample();
        check_eq("rd_ready", DW'(req_ready), 2'b01);
        check_eq("rd_rdw_en", DW'(ram_rdw_en), 0);
        check_eq("rd_addr", DW'(ram_addr), 10'h005);
        check_eq("rd_no_early_rsp", DW'(rsp_valid), 0);
        tick();
        drop(0);
        sample();
        check_eq("rd_rsp_valid", DW'(rsp_valid), 2'b01);
        check_eq("rd_rsp_data", rsp_rdata[DW-1:0], 64'hDEAD_BEEF);
        check_eq("idle_clk_en", DW'(ram_clk_en), 0);
        check_eq("idle_addr", DW'(ram_addr), 0);
        tick();
        sample();
        check_eq("rsp_drop", DW'(rsp_valid), 0);
        check_eq("rsp_hold_last", rsp_rdata[DW-1:0], 64'hDEAD_BEEF);
        tick();

        // Contention from a freshly reset pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1'b0, 10'h005, '0, '0);
        drive(1, 1'b0, 10'h005, '0, '0);
        for (int k = 0; k < 4; k++) begin
            sample();
`ifdef SP_RAM_ARB_RR_EN
            check_eq("cont_grant", DW'(req_ready), (k % 2 == 0) ? 2'b01 : 2'b10);
            check_eq("cont_rsp", DW'(rsp_valid), (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10));
`else
            check_eq("cont_grant", DW'(req_ready), 2'b01);
            check_eq("cont_rsp", DW'(rsp_valid), (k == 0) ? 2'b00 : 2'b01);
`endif
            tick();
        end
        drop(0); drop(1);
        tick();

        // Backpressure on port 0 while port 1 overwrites the address.
        wr(1, 10'h010, 64'h11, ONES);
        rsp_ready = 2'b10;
        drive(0, 1'b0, 10'h010, '0, '0);
        sample();
        check_eq("bp_accept", DW'(req_ready), 2'b01);
        tick();
        drive(1, 1'b1, 10'h010, 64'h22, ONES);
        sample();
        check_eq("bp_grant_p1", DW'(req_ready), 2'b10);
        check_eq("bp_rsp_valid", DW'(rsp_valid[0]), 1);
        check_eq("bp_rsp_data", rsp_rdata[DW-1:0], 64'h11);
        tick();
        drop(1);
        for (int k = 0; k < 3; k++) begin
            sample();
            check_eq("bp_blocked", DW'(req_ready), 0);
            check_eq("bp_hold_valid", DW'(rsp_valid[0]), 1);
            check_eq("bp_hold_data", rsp_rdata[DW-1:0], 64'h11);
            tick();
        end
        rsp_ready = 2'b11;
        sample();
        check_eq("bp_release_grant", DW'(req_ready), 2'b01);
        check_eq("bp_release_data", rsp_rdata[DW-1:0], 64'h11);
        tick();
        drop(0);
        sample();
        check_eq("bp_new_valid", DW'(rsp_valid[0]), 1);
        check_eq("bp_new_data", rsp_rdata[DW-1:0], 64'h22);
        tick();

        // Masked write merges into existing contents.
        wr(0, 10'h020, 64'hFFFF_FFFF, ONES);
        wr(0, 10'h020, 64'h0, 64'h0000_FFFF);
        drive(0, 1'b0, 10'h020, '0, '0);
        sample();
        check_eq("mask_rd_ready", DW'(req_ready), 2'b01);
        tick();
        drop(0);
        sample();
        check_eq("mask_data", rsp_rdata[DW-1:0], 64'hFFFF_0000);
        tick();

        // Reset the cycle after a read accept.
        drive(0, 1'b0, 10'h020, '0, '0);
        sample();
        check_eq("rr_accept", DW'(req_ready), 2'b01);
        tick();
        rst = 1'b1;
        drive(1, 1'b0, 10'h005, '0, '0);
        for (int k = 0; k < 2; k++) begin
            sample();
            check_eq("rstmid_rsp", DW'(rsp_valid), 0);
            check_eq("rstmid_clk_en", DW'(ram_clk_en), 0);
            check_eq("rstmid_ready", DW'(req_ready), 0);
            tick();
        end
        rst = 1'b0;
        sample();
        check_eq("post_rst_grant", DW'(req_ready), 2'b01);
        check_eq("post_rst_rsp", DW'(rsp_valid), 0);
        tick();
        drop(0); drop(1);
        sample();
        check_eq("post_rst_rsp_valid", DW'(rsp_valid), 2'b01);
        check_eq("post_rst_rsp_data", rsp_rdata[DW-1:0], 64'hFFFF_0000);
        tick();

        // Streaming reads from port 1.
        for (int i = 0; i < 8; i++) wr(1, AW'(10'h030 + i), DW'(64'h1000 + i), ONES);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                drive(1, 1'b0, AW'(10'h030 + k), '0, '0);
                exp_q.push_back(DW'(64'h1000 + k));
            end else begin
                drop(1);
            end
            sample();
            if (k < 8) check_eq("stream_grant", DW'(req_ready[1]), 1);
            check_eq("stream_valid", DW'(rsp_valid[1]), DW'(k >= 1 && k <= 8));
            if (rsp_valid[1] && exp_q.size() > 0) check_eq("stream_data", rsp_rdata[2*DW-1:DW], exp_q.pop_front());
            tick();
        end
        check_eq("stream_drain", DW'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
